// File: rtl/pattern_stream_generator.sv
// pattern_stream_generator
// Synthetic RGB565 frame source feeding the 17-bit pixel queue ({marker, data}).
// Frame = start marker, then per row an optional row marker and FRAME_WIDTH
// pixels, then an optional frame-end marker, followed by an idle gap.
// A word is issued only in a cycle where queue_full is sampled low; the word
// and its write strobe appear on the registered outputs one cycle later.
// Pattern selection (mode/solid_color) is latched at frame start so that
// mid-frame changes only take effect on the next frame.

module pattern_stream_generator #(
    parameter int unsigned FRAME_WIDTH     = 480,
    parameter int unsigned FRAME_HEIGHT    = 272,
    parameter int unsigned NUM_BARS        = 8,
    parameter int unsigned CHECKER_LOG2    = 4,
    parameter int unsigned SEND_EXTRA_DATA = 1,
    parameter int unsigned FRAME_GAP       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_color,
    input  logic        queue_full,
    output logic [16:0] queue_data,
    output logic        queue_wr_en,
    output logic        queue_clk,
    output logic [15:0] frame_count,
    output logic        busy
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_FRAME_START = 3'd1;
    localparam logic [2:0] S_ROW_START   = 3'd2;
    localparam logic [2:0] S_PIXELS      = 3'd3;
    localparam logic [2:0] S_FRAME_END   = 3'd4;
    localparam logic [2:0] S_GAP         = 3'd5;

    // ------------------------------------------------------------------
    // Elaboration-time geometry
    // ------------------------------------------------------------------
    localparam int unsigned BAR_W     = FRAME_WIDTH / NUM_BARS;
    // With fewer columns than bars every column falls past the last full
    // bar, so each row starts directly in the final bar.
    localparam logic [2:0]  START_BAR = (BAR_W == 0) ? 3'(NUM_BARS - 1) : 3'd0;
    localparam logic [2:0]  LAST_BAR  = 3'(NUM_BARS - 1);
    localparam logic [10:0] BAR_W_M1  = (BAR_W == 0) ? 11'd0 : 11'(BAR_W - 1);
    localparam logic [10:0] COL_LAST  = 11'(FRAME_WIDTH - 1);
    localparam logic [10:0] ROW_LAST  = 11'(FRAME_HEIGHT - 1);
    // A zero gap still spends one cycle in GAP.
    localparam logic [15:0] GAP_LAST  = (FRAME_GAP == 0) ? 16'd0 : 16'(FRAME_GAP - 1);
    localparam logic        SEND_MARK = (SEND_EXTRA_DATA != 0);

    localparam logic [16:0] WORD_FRAME_START = 17'h10000;
    localparam logic [16:0] WORD_ROW_START   = 17'h10001;
    localparam logic [16:0] WORD_FRAME_END   = 17'h1FFFF;

    // ------------------------------------------------------------------
    // Colour-bar lookup (classic white/yellow/cyan/green/magenta/red/blue/black)
    // ------------------------------------------------------------------
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            3'd7:    c = 16'h0000;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    // Grey ramp: 5-bit level replicated into R, G (upper 5 bits) and B.
    function automatic logic [15:0] ramp_color(input logic [4:0] v);
        return {v, v, 1'b0, v};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]  state_q,       state_d;
    logic [10:0] col_q,         col_d;
    logic [10:0] row_q,         row_d;
    logic [2:0]  bar_q,         bar_d;
    logic [10:0] pib_q,         pib_d;      // pixel position inside current bar
    logic [15:0] gap_q,         gap_d;
    logic [1:0]  mode_q,        mode_d;
    logic [15:0] solid_q,       solid_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [16:0] queue_data_q,  queue_data_d;
    logic        queue_wr_en_q, queue_wr_en_d;
    logic        busy_q,        busy_d;

    logic [15:0] pixel_s;
    logic [4:0]  ramp_v_s;
    logic        checker_s;

    // Pixel colour for the current (col,row) under the latched mode.
    always_comb begin
        // mod 32 of (col + f) only needs the low five bits of each term
        ramp_v_s  = col_q[4:0] + frame_count_q[4:0];
        checker_s = col_q[CHECKER_LOG2] ^ row_q[CHECKER_LOG2] ^ frame_count_q[0];
        pixel_s   = 16'h0000;
        case (mode_q)
            2'd0:    pixel_s = bar_color(bar_q);
            2'd1:    pixel_s = ramp_color(ramp_v_s);
            2'd2:    pixel_s = checker_s ? 16'hFFFF : 16'h0000;
            2'd3:    pixel_s = solid_q;
            default: pixel_s = 16'h0000;
        endcase
    end

    // Next-state, counter and output-word computation.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        bar_d         = bar_q;
        pib_d         = pib_q;
        gap_d         = gap_q;
        mode_d        = mode_q;
        solid_d       = solid_q;
        frame_count_d = frame_count_q;
        queue_data_d  = queue_data_q;
        queue_wr_en_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    mode_d  = mode;
                    solid_d = solid_color;
                    col_d   = 11'd0;
                    row_d   = 11'd0;
                    bar_d   = START_BAR;
                    pib_d   = 11'd0;
                    state_d = S_FRAME_START;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_FRAME_START: begin
                if (!queue_full) begin
                    queue_wr_en_d = 1'b1;
                    queue_data_d  = WORD_FRAME_START;
                    state_d       = SEND_MARK ? S_ROW_START : S_PIXELS;
                end else begin
                    state_d = S_FRAME_START;
                end
            end

            S_ROW_START: begin
                if (!queue_full) begin
                    queue_wr_en_d = 1'b1;
                    queue_data_d  = WORD_ROW_START;
                    state_d       = S_PIXELS;
                end else begin
                    state_d = S_ROW_START;
                end
            end

            S_PIXELS: begin
                if (!queue_full) begin
                    queue_wr_en_d = 1'b1;
                    queue_data_d  = {1'b0, pixel_s};
                    if (col_q == COL_LAST) begin
                        col_d = 11'd0;
                        bar_d = START_BAR;
                        pib_d = 11'd0;
                        if (row_q == ROW_LAST) begin
                            state_d = S_FRAME_END;
                        end else begin
                            row_d   = row_q + 11'd1;
                            state_d = SEND_MARK ? S_ROW_START : S_PIXELS;
                        end
                    end else begin
                        col_d = col_q + 11'd1;
                        // The final bar absorbs the remainder columns, so
                        // the in-bar counter stops advancing once there.
                        if (bar_q == LAST_BAR) begin
                            pib_d = pib_q;
                        end else if (pib_q == BAR_W_M1) begin
                            bar_d = bar_q + 3'd1;
                            pib_d = 11'd0;
                        end else begin
                            pib_d = pib_q + 11'd1;
                        end
                    end
                end else begin
                    state_d = S_PIXELS;
                end
            end

            S_FRAME_END: begin
                if (SEND_MARK) begin
                    if (!queue_full) begin
                        queue_wr_en_d = 1'b1;
                        queue_data_d  = WORD_FRAME_END;
                        frame_count_d = frame_count_q + 16'd1;
                        gap_d         = 16'd0;
                        state_d       = S_GAP;
                    end else begin
                        state_d = S_FRAME_END;
                    end
                end else begin
                    frame_count_d = frame_count_q + 16'd1;
                    gap_d         = 16'd0;
                    state_d       = S_GAP;
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    gap_d   = gap_q + 16'd1;
                    state_d = S_GAP;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_GAP);
    end

    // State, counters and registered outputs; synchronous reset abandons any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            col_q         <= 11'd0;
            row_q         <= 11'd0;
            bar_q         <= 3'd0;
            pib_q         <= 11'd0;
            gap_q         <= 16'd0;
            mode_q        <= 2'd0;
            solid_q       <= 16'h0000;
            frame_count_q <= 16'd0;
            queue_data_q  <= 17'h00000;
            queue_wr_en_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            bar_q         <= bar_d;
            pib_q         <= pib_d;
            gap_q         <= gap_d;
            mode_q        <= mode_d;
            solid_q       <= solid_d;
            frame_count_q <= frame_count_d;
            queue_data_q  <= queue_data_d;
            queue_wr_en_q <= queue_wr_en_d;
            busy_q        <= busy_d;
        end
    end

    assign queue_data  = queue_data_q;
    assign queue_wr_en = queue_wr_en_q;
    assign queue_clk   = clk;
    assign frame_count = frame_count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pattern_stream_generator.sv
// Scoreboard bench for pattern_stream_generator: four instances with
// different geometries; expected words are pushed from an independent
// reference model and popped as each DUT writes to its queue.

module tb_pattern_stream_generator;

    logic clk;
    logic rst;
    logic throttle_a;

    // Instance A: W16 H4 4 bars, checker log2=2, markers, gap 3
    logic        en_a, full_a, wr_a, qclk_a, busy_a, full_smp_a;
    logic [1:0]  mode_a;
    logic [15:0] solid_a, fc_a;
    logic [16:0] q_a;
    // Instance B: W10 H2 3 bars, markers, gap 0
    logic        en_b, full_b, wr_b, qclk_b, busy_b;
    logic [1:0]  mode_b;
    logic [15:0] solid_b, fc_b;
    logic [16:0] q_b;
    // Instance C: W40 H1 ramp, markers, gap 16
    logic        en_c, full_c, wr_c, qclk_c, busy_c;
    logic [1:0]  mode_c;
    logic [15:0] solid_c, fc_c;
    logic [16:0] q_c;
    // Instance D: W3 H2 no markers, gap 0
    logic        en_d, full_d, wr_d, qclk_d, busy_d;
    logic [1:0]  mode_d;
    logic [15:0] solid_d, fc_d;
    logic [16:0] q_d;

    logic [16:0] exp_a[$], exp_b[$], exp_c[$], exp_d[$];
    logic [16:0] cap_b[$], cap_c[$], cap_d[$];
    int rx_a, rx_b, rx_c, rx_d;
    int n_chk, n_err;
    int base;

    pattern_stream_generator #(.FRAME_WIDTH(16), .FRAME_HEIGHT(4), .NUM_BARS(4),
        .CHECKER_LOG2(2), .SEND_EXTRA_DATA(1), .FRAME_GAP(3)) u_a (
        .clk(clk), .reset(rst), .enable(en_a), .mode(mode_a), .solid_color(solid_a),
        .queue_full(full_a), .queue_data(q_a), .queue_wr_en(wr_a), .queue_clk(qclk_a),
        .frame_count(fc_a), .busy(busy_a));

    pattern_stream_generator #(.FRAME_WIDTH(10), .FRAME_HEIGHT(2), .NUM_BARS(3),
        .CHECKER_LOG2(4), .SEND_EXTRA_DATA(1), .FRAME_GAP(0)) u_b (
        .clk(clk), .reset(rst), .enable(en_b), .mode(mode_b), .solid_color(solid_b),
        .queue_full(full_b), .queue_data(q_b), .queue_wr_en(wr_b), .queue_clk(qclk_b),
        .frame_count(fc_b), .busy(busy_b));

    pattern_stream_generator #(.FRAME_WIDTH(40), .FRAME_HEIGHT(1), .NUM_BARS(8),
        .CHECKER_LOG2(4), .SEND_EXTRA_DATA(1), .FRAME_GAP(16)) u_c (
        .clk(clk), .reset(rst), .enable(en_c), .mode(mode_c), .solid_color(solid_c),
        .queue_full(full_c), .queue_data(q_c), .queue_wr_en(wr_c), .queue_clk(qclk_c),
        .frame_count(fc_c), .busy(busy_c));

    pattern_stream_generator #(.FRAME_WIDTH(3), .FRAME_HEIGHT(2), .NUM_BARS(8),
        .CHECKER_LOG2(4), .SEND_EXTRA_DATA(0), .FRAME_GAP(0)) u_d (
        .clk(clk), .reset(rst), .enable(en_d), .mode(mode_d), .solid_color(solid_d),
        .queue_full(full_d), .queue_data(q_d), .queue_wr_en(wr_d), .queue_clk(qclk_d),
        .frame_count(fc_d), .busy(busy_d));

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference pixel: bars via plain division, ramp and checker by formula
    function automatic logic [15:0] model_pix(input int w, input int nb, input int cl,
                                              input int md, input int col, input int row,
                                              input int f, input logic [15:0] solid);
        int bw, bar;
        logic [4:0] v;
        logic [15:0] r;
        r = 16'h0000;
        case (md)
            0: begin
                bw = w / nb;
                bar = (bw == 0) ? nb - 1 : col / bw;
                if (bar > nb - 1) bar = nb - 1;
                case (bar)
                    0: r = 16'hFFFF;
                    1: r = 16'hFFE0;
                    2: r = 16'h07FF;
                    3: r = 16'h07E0;
                    4: r = 16'hF81F;
                    5: r = 16'hF800;
                    6: r = 16'h001F;
                    default: r = 16'h0000;
                endcase
            end
            1: begin
                v = 5'((col + (f & 32'h7FF)) % 32);
                r = {v, v, 1'b0, v};
            end
            2: r = ((((col >> cl) ^ (row >> cl) ^ f) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: r = solid;
        endcase
        return r;
    endfunction

    task automatic push_word(input int inst, input logic [16:0] wd);
        case (inst)
            0: exp_a.push_back(wd);
            1: exp_b.push_back(wd);
            2: exp_c.push_back(wd);
            default: exp_d.push_back(wd);
        endcase
    endtask

    task automatic push_frame(input int inst, input int w, input int h, input int nb,
                              input int cl, input int send, input int md, input int f,
                              input logic [15:0] solid);
        push_word(inst, 17'h10000);
        for (int r = 0; r < h; r++) begin
            if (send != 0) push_word(inst, 17'h10001);
            for (int c = 0; c < w; c++)
                push_word(inst, {1'b0, model_pix(w, nb, cl, md, c, r, f, solid)});
        end
        if (send != 0) push_word(inst, 17'h1FFFF);
    endtask

    function automatic logic [15:0] get_fc(input int inst);
        case (inst)
            0: return fc_a;
            1: return fc_b;
            2: return fc_c;
            default: return fc_d;
        endcase
    endfunction

    task automatic wait_fc(input int inst, input int target);
        for (int i = 0; i < 5000; i++) begin
            if (get_fc(inst) == 16'(target)) break;
            tick;
        end
        check_val($sformatf("fc_wait%0d", inst), {16'h0, get_fc(inst)}, target);
    endtask

    task automatic wait_rx_a(input int target);
        for (int i = 0; i < 5000; i++) begin
            if (rx_a >= target) break;
            tick;
        end
        check_val("a_rx_wait", rx_a, target);
    endtask

    // Capture the queue_full value the DUT sampled at each edge
    always @(posedge clk) full_smp_a <= full_a;

    // Pseudo-random back-pressure on instance A
    initial begin
        full_a = 1'b0;
        forever begin
            @(negedge clk);
            full_a = throttle_a ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Scoreboard monitors: pop and compare each written word
    always @(negedge clk) begin
        if (wr_a) begin
            rx_a++;
            check_val("a_wr_after_full", {31'h0, full_smp_a}, 0);
            if (exp_a.size() == 0) check_val("a_unexpected", exp_a.size(), 1);
            else check_val("a_word", {15'h0, q_a}, {15'h0, exp_a.pop_front()});
        end
        if (wr_b) begin
            rx_b++;
            cap_b.push_back(q_b);
            if (exp_b.size() == 0) check_val("b_unexpected", exp_b.size(), 1);
            else check_val("b_word", {15'h0, q_b}, {15'h0, exp_b.pop_front()});
        end
        if (wr_c) begin
            rx_c++;
            cap_c.push_back(q_c);
            if (exp_c.size() == 0) check_val("c_unexpected", exp_c.size(), 1);
            else check_val("c_word", {15'h0, q_c}, {15'h0, exp_c.pop_front()});
        end
        if (wr_d) begin
            rx_d++;
            cap_d.push_back(q_d);
            if (exp_d.size() == 0) check_val("d_unexpected", exp_d.size(), 1);
            else check_val("d_word", {15'h0, q_d}, {15'h0, exp_d.pop_front()});
        end
    end

    // Main sequence
    initial begin
        n_chk = 0; n_err = 0;
        rx_a = 0; rx_b = 0; rx_c = 0; rx_d = 0;
        rst = 1'b1; throttle_a = 1'b0;
        en_a = 1'b0; mode_a = 2'd0; solid_a = 16'h0;
        en_b = 1'b0; mode_b = 2'd0; solid_b = 16'h0; full_b = 1'b0;
        en_c = 1'b0; mode_c = 2'd0; solid_c = 16'h0; full_c = 1'b0;
        en_d = 1'b0; mode_d = 2'd0; solid_d = 16'h0; full_d = 1'b0;
        repeat (3) tick;
        check_val("rst_data", {15'h0, q_a}, 0);
        check_val("rst_wr", {31'h0, wr_a}, 0);
        check_val("rst_fc", {16'h0, fc_a}, 0);
        check_val("rst_busy", {31'h0, busy_a}, 0);
        check_val("qclk", {31'h0, qclk_a}, {31'h0, clk});
        rst = 1'b0;
        tick;

        // A1: colour bars, unthrottled
        push_frame(0, 16, 4, 4, 2, 1, 0, 0, 16'h0);
        base = rx_a;
        en_a = 1'b1;
        tick; tick;
        check_val("a_busy_run", {31'h0, busy_a}, 1);
        wait_fc(0, 1);
        en_a = 1'b0;
        repeat (8) tick;
        check_val("a1_words", rx_a - base, 70);
        check_val("a1_left", exp_a.size(), 0);
        check_val("a1_busy_idle", {31'h0, busy_a}, 0);

        // A2: throttled checker frame, mode switched mid-frame to solid
        throttle_a = 1'b1;
        mode_a = 2'd2;
        push_frame(0, 16, 4, 4, 2, 1, 2, 1, 16'h0);
        push_frame(0, 16, 4, 4, 2, 1, 3, 2, 16'hA5C3);
        base = rx_a;
        en_a = 1'b1;
        wait_rx_a(base + 20);
        mode_a = 2'd3;
        solid_a = 16'hA5C3;
        wait_fc(0, 3);
        en_a = 1'b0;
        repeat (10) tick;
        throttle_a = 1'b0;
        check_val("a2_words", rx_a - base, 140);
        check_val("a2_left", exp_a.size(), 0);

        // A3: reset mid-frame (row 2 col 5), restart with enable held
        mode_a = 2'd0;
        push_frame(0, 16, 4, 4, 2, 1, 0, 3, 16'h0);
        base = rx_a;
        en_a = 1'b1;
        wait_rx_a(base + 42);
        rst = 1'b1;
        tick;
        exp_a.delete();
        check_val("a3_rst_data", {15'h0, q_a}, 0);
        check_val("a3_rst_wr", {31'h0, wr_a}, 0);
        check_val("a3_rst_fc", {16'h0, fc_a}, 0);
        tick;
        check_val("a3_rst_busy", {31'h0, busy_a}, 0);
        push_frame(0, 16, 4, 4, 2, 1, 0, 0, 16'h0);
        base = rx_a;
        rst = 1'b0;
        tick;
        check_val("a3_fc_after", {16'h0, fc_a}, 0);
        wait_fc(0, 1);
        en_a = 1'b0;
        repeat (8) tick;
        check_val("a3_words", rx_a - base, 70);
        check_val("a3_left", exp_a.size(), 0);

        // B: uneven bar split
        push_frame(1, 10, 2, 3, 4, 1, 0, 0, 16'h0);
        en_b = 1'b1;
        wait_fc(1, 1);
        en_b = 1'b0;
        repeat (5) tick;
        check_val("b_words", rx_b, 24);
        check_val("b_left", exp_b.size(), 0);
        check_val("b_col0", {15'h0, cap_b[2]}, 32'h0FFFF);
        check_val("b_col3", {15'h0, cap_b[5]}, 32'h0FFE0);
        check_val("b_col9", {15'h0, cap_b[11]}, 32'h007FF);

        // C: ramp over two frames
        mode_c = 2'd1;
        push_frame(2, 40, 1, 8, 4, 1, 1, 0, 16'h0);
        push_frame(2, 40, 1, 8, 4, 1, 1, 1, 16'h0);
        en_c = 1'b1;
        wait_fc(2, 2);
        en_c = 1'b0;
        repeat (20) tick;
        check_val("c_words", rx_c, 86);
        check_val("c_left", exp_c.size(), 0);
        check_val("c_f0_col0", {15'h0, cap_c[2]}, 32'h00000);
        check_val("c_f0_col1", {15'h0, cap_c[3]}, 32'h00841);
        check_val("c_f0_col31", {15'h0, cap_c[33]}, 32'h0FFDF);
        check_val("c_f0_col32", {15'h0, cap_c[34]}, 32'h00000);
        check_val("c_f1_col0", {15'h0, cap_c[45]}, 32'h00841);

        // D: solid colour, no markers
        mode_d = 2'd3;
        solid_d = 16'h1234;
        push_frame(3, 3, 2, 8, 4, 0, 3, 0, 16'h1234);
        en_d = 1'b1;
        wait_fc(3, 1);
        en_d = 1'b0;
        repeat (5) tick;
        check_val("d_words", rx_d, 7);
        check_val("d_left", exp_d.size(), 0);
        check_val("d_first", {15'h0, cap_d[0]}, 32'h10000);
        check_val("d_last", {15'h0, cap_d[6]}, 32'h01234);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
